user_input_debounced: RTL
=========================

Name: user_input_debounced

Overview:
Parametrised successor to the player button front end. Synchronises and debounces each of NUM_KEYS active-low push-buttons per key, then converts debounced press edges into one-shot game commands. Commands are held on a valid/ack handshake toward the game controller, and deal presses are reported as single-cycle pulses. Sits between the board keys and the blackjack game FSM.

Parameters:
NUM_KEYS, 4, number of key inputs (minimum 3: key 0 = hit, key 1 = stand, key 2 = deal; keys 3 and up are report-only)
SYNC_STAGES, 2, flip-flop stages in each key synchroniser (minimum 2)
DEBOUNCE_CYCLES, 25000000, consecutive stable synchronised cycles required before a debounced level changes (minimum 1)
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; not overridden)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_KEY  in  NUM_KEYS  raw buttons; 0 = pressed
i_turnIndicator  in  1  player's turn; gates hit/stand
i_ack  in  1  consumer accepts the held command this cycle
o_command  out  `gameCommand  held command; `COMMAND_NONE when not valid
o_ready  out  1  command valid (pending)
o_dealButtonPushed  out  1  one-cycle pulse per debounced deal press
o_keyLevel  out  NUM_KEYS  debounced levels; 1 = pressed
o_keyPressed  out  NUM_KEYS  one-cycle pulse per debounced press, all keys
o_overrun  out  1  one-cycle pulse when a hit/stand press is dropped because a command is pending

Behaviour:
- Reset (asynchronous): synchroniser flops = 1 (released); counters = 0; debounced levels = released; o_command = `COMMAND_NONE; all other outputs = 0.
- Per key, the debounce runs on the synchronised level s:
  - If s equals the debounced level, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and s still differs, the debounced level toggles at that edge and the counter clears.
- Latency: the debounced level changes SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples the new pin level.
  - Press pulse p[k] = debounced pressed & previous-cycle not pressed (combinational).
  - o_keyPressed, o_dealButtonPushed, o_overrun and the command register update at the next edge (total SYNC_STAGES+DEBOUNCE_CYCLES+1).
- A bounce of fewer than DEBOUNCE_CYCLES synchronised cycles produces no output. Release never generates commands. Holding a key generates exactly one press.
- Command load on a cycle with p[0] or p[1]:
  - Loads only if i_turnIndicator=1 in that cycle; otherwise the press is dropped silently.
  - p[1] and p[0] together → `COMMAND_STAND (stand wins).
- Handshake:
  - o_ready=1 and o_command stay constant until a cycle with i_ack=1; they clear at the following edge.
  - i_ack while o_ready=0 is ignored.
  - New press while pending and no i_ack → press dropped, o_overrun pulses, held command unchanged.
  - New press in the same cycle as i_ack → new command loaded, o_ready stays 1, no overrun.
- Deal (p[2]) pulses o_dealButtonPushed regardless of i_turnIndicator or a pending command. It never affects o_command.
- i_turnIndicator falling does not cancel a pending command.
- Reset asserted mid-debounce or with a command pending → all state returns to reset values immediately. Keys still held at release of reset must re-debounce and then produce a press.

Decomposition:
- Add key-role index constants (KEY_HIT=0, KEY_STAND=1, KEY_DEAL=2) to gameCommand.svh alongside the existing `gameCommand/`COMMAND_* definitions; no new command encodings.
- One sub-module, key_debouncer: synchroniser, counter and debounced-level register with parameters SYNC_STAGES and DEBOUNCE_CYCLES. Instantiate it NUM_KEYS times in a generate loop.
- The top level holds edge detection, the turn gating, the priority encoder and the command/handshake register.

Test Plan:
All tests use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, NUM_KEYS=4.
- Clean press: i_turnIndicator=1, i_KEY[0] held low from edge 0 → o_ready=1 with o_command=`COMMAND_HIT at edge 7. Pulse o_keyPressed[0] for 1 cycle. i_ack at edge 10 → o_ready=0 and `COMMAND_NONE at edge 11.
- Bounce: i_KEY[1] low 3 cycles, high 1, low 3, then high → no change on o_keyLevel[1], o_keyPressed, o_ready or o_overrun.
- Simultaneous keys and turn gating:
  - i_KEY[1:0]=00 with i_turnIndicator=1 → `COMMAND_STAND.
  - Same press with i_turnIndicator=0 → o_ready stays 0, no overrun.
- Pending overrun and ack collision:
  - Hit pending with no ack, then stand press → o_overrun pulses once and o_command stays HIT.
  - Repeat with i_ack in the stand pulse cycle → o_command=STAND, o_ready held at 1.
- Deal independence: i_turnIndicator=0 with HIT pending, i_KEY[2] pressed for 20 cycles → exactly one o_dealButtonPushed pulse at edge 7, and o_command unchanged.
- Reset mid-operation: assert i_reset asynchronously at edge 5 of a press and while a command is pending → outputs zero immediately. A key held through release of reset produces a command 7 edges after release.

Source files
------------

// File: rtl/user_input_debounced_pkg.sv
// Shared command encodings and key-role indices for the player button front end.
`ifndef GAME_COMMAND_SVH
`define GAME_COMMAND_SVH
`define gameCommand  logic [1:0]
`define COMMAND_NONE 2'd0
`define COMMAND_HIT  2'd1
`define COMMAND_STAND 2'd2
`endif

package user_input_debounced_pkg;
  localparam int unsigned KEY_HIT   = 0;
  localparam int unsigned KEY_STAND = 1;
  localparam int unsigned KEY_DEAL  = 2;
endpackage

// File: rtl/user_input_debounced_key_debouncer.sv
// One active-low key: synchroniser chain, stability counter and debounced level (1 = pressed).
module key_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 25000000,
  localparam int unsigned CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_n,
  output logic o_level
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   s_pressed;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], i_key_n};
    s_pressed = ~sync_q[SYNC_STAGES-1];
    cnt_d     = '0;
    level_d   = level_q;
    // The final agreeing cycle toggles the level instead of advancing the counter.
    if (s_pressed != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = s_pressed;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign o_level = level_q;

endmodule

// File: rtl/user_input_debounced.sv
// Debounced key front end: press edges become hit/stand commands on a valid/ack
// handshake, deal presses become single-cycle pulses.
module user_input_debounced
  import user_input_debounced_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 25000000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NUM_KEYS-1:0] i_KEY,
  input  logic                i_turnIndicator,
  input  logic                i_ack,
  output `gameCommand         o_command,
  output logic                o_ready,
  output logic                o_dealButtonPushed,
  output logic [NUM_KEYS-1:0] o_keyLevel,
  output logic [NUM_KEYS-1:0] o_keyPressed,
  output logic                o_overrun
);

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] level_prev_q, level_prev_d;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] key_pressed_q, key_pressed_d;
  logic                deal_q, deal_d;
  logic                overrun_q, overrun_d;
  logic                ready_q, ready_d;
  `gameCommand         cmd_q, cmd_d;
  logic                play_req;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debouncer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_key_n(i_KEY[k]),
      .o_level(level[k])
    );
  end

  always_comb begin
    press         = level & ~level_prev_q;
    level_prev_d  = level;
    key_pressed_d = press;
    deal_d        = press[KEY_DEAL];
    overrun_d     = 1'b0;
    ready_d       = ready_q;
    cmd_d         = cmd_q;
    play_req      = i_turnIndicator & (press[KEY_HIT] | press[KEY_STAND]);
    // An ack in the same cycle frees the slot, so the new press loads instead of overrunning.
    if (play_req) begin
      if (ready_q && !i_ack) begin
        overrun_d = 1'b1;
      end else begin
        ready_d = 1'b1;
        cmd_d   = press[KEY_STAND] ? `COMMAND_STAND : `COMMAND_HIT;
      end
    end else if (ready_q && i_ack) begin
      ready_d = 1'b0;
      cmd_d   = `COMMAND_NONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      level_prev_q  <= '0;
      key_pressed_q <= '0;
      deal_q        <= 1'b0;
      overrun_q     <= 1'b0;
      ready_q       <= 1'b0;
      cmd_q         <= `COMMAND_NONE;
    end else begin
      level_prev_q  <= level_prev_d;
      key_pressed_q <= key_pressed_d;
      deal_q        <= deal_d;
      overrun_q     <= overrun_d;
      ready_q       <= ready_d;
      cmd_q         <= cmd_d;
    end
  end

  assign o_command          = cmd_q;
  assign o_ready            = ready_q;
  assign o_dealButtonPushed = deal_q;
  assign o_keyLevel         = level;
  assign o_keyPressed       = key_pressed_q;
  assign o_overrun          = overrun_q;

endmodule
